// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_stage_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem handshake, redirect draining and the IF/ID register.
module fetch_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_fetch,
  input  logic             stall_decode,
  input  logic             flush_decode,
  input  logic             pcsrc_decode,
  input  logic [WIDTH-1:0] pc_branch,
  input  logic             jump_decode,
  input  logic [WIDTH-1:0] pc_jump,
  fetch_stage_if.master    imem,
  output logic [WIDTH-1:0] instr_decode,
  output logic [WIDTH-1:0] pc_decode,
  output logic             valid_decode,
  output logic             fetch_busy
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pcd_q, pcd_d;
  logic             valid_q, valid_d;

  logic             req;
  logic             redirect;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc_inc;
  logic             load;
  logic [WIDTH-1:0] load_word;

  assign redirect = pcsrc_decode | jump_decode;
  assign target   = pcsrc_decode ? pc_branch : pc_jump;
  assign pc_inc   = pc_q + WIDTH'(4);

  // A request already on the bus is never withdrawn by stall_fetch (pend_q).
  always_comb begin
    req = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH:   req = !stall_fetch || pend_q;
        DRAIN:   req = 1'b1;
        default: req = 1'b0;
      endcase
    end
  end

  // DRAIN replays the abandoned address while pc_q already holds the redirect target.
  assign imem.imem_req  = req;
  assign imem.imem_addr = (state_q == DRAIN) ? addr_q : pc_q;
  assign fetch_busy     = (state_q == DRAIN) || ((state_q == FETCH) && req && !imem.imem_ack);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    pend_d    = 1'b0;
    buf_d     = buf_q;
    load      = 1'b0;
    load_word = imem.imem_rdata;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d = target;
          if (req && !imem.imem_ack) begin
            state_d = DRAIN;
            addr_d  = pc_q;
          end
        end else if (req && imem.imem_ack) begin
          if (stall_decode) begin
            state_d = HOLD;
            buf_d   = imem.imem_rdata;
          end else begin
            load = 1'b1;
            pc_d = pc_inc;
          end
        end else begin
          pend_d = req;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall_decode) begin
          load      = 1'b1;
          load_word = buf_q;
          pc_d      = pc_inc;
          state_d   = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) pc_d = target;
        if (imem.imem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    instr_d = instr_q;
    pcd_d   = pcd_q;
    valid_d = valid_q;
    if (flush_decode) begin
      instr_d = '0;
      pcd_d   = '0;
      valid_d = 1'b0;
    end else if (!stall_decode) begin
      instr_d = load ? load_word : '0;
      pcd_d   = load ? pc_inc : '0;
      valid_d = load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      pend_q  <= 1'b0;
      buf_q   <= '0;
      instr_q <= '0;
      pcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      valid_q <= valid_d;
    end
  end

  assign instr_decode = instr_q;
  assign pc_decode    = pcd_q;
  assign valid_decode = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: wait-state memory model, vector table and scoreboard of IF/ID words.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall_fetch, stall_decode, flush_decode;
  logic        pcsrc_decode, jump_decode;
  logic [31:0] pc_branch, pc_jump;
  logic [31:0] instr_decode, pc_decode;
  logic        valid_decode, fetch_busy;

  int          checks   = 0;
  int          failures = 0;

  int          waitst   = 0;
  int          cnt      = 0;
  logic [31:0] key      = '0;
  logic        hold_prev = 1'b1;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } sb_t;
  sb_t sbq[$];

  typedef struct {
    int          waitst;
    logic        sd;
    logic        req;
    logic [31:0] addr;
    logic        busy;
    logic        valid;
    logic        ack;
  } vec_t;
  vec_t vecs[7];

  fetch_stage_if #(.WIDTH(32)) imem ();

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_fetch  (stall_fetch),
    .stall_decode (stall_decode),
    .flush_decode (flush_decode),
    .pcsrc_decode (pcsrc_decode),
    .pc_branch    (pc_branch),
    .jump_decode  (jump_decode),
    .pc_jump      (pc_jump),
    .imem         (imem),
    .instr_decode (instr_decode),
    .pc_decode    (pc_decode),
    .valid_decode (valid_decode),
    .fetch_busy   (fetch_busy)
  );

  always #5 clk = ~clk;

  // Memory: acks after waitst cycles of continuous request; rdata = addr ^ key.
  assign imem.imem_ack   = imem.imem_req && (cnt >= waitst);
  assign imem.imem_rdata = imem.imem_ack ? (imem.imem_addr ^ key) : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (rst || !imem.imem_req || imem.imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
    hold_prev <= stall_decode && !flush_decode;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every freshly loaded IF/ID word must match the oldest expected entry.
  always @(negedge clk) begin
    if (valid_decode === 1'b1 && !hold_prev) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_word", instr_decode, 32'hxxxx_xxxx);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("sb_instr", instr_decode, e.instr);
        chk("sb_pc", pc_decode, e.pc);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input string tag, input logic r, input logic [31:0] a, input logic b);
    #1;
    chk({tag, "_req"}, {31'b0, imem.imem_req}, {31'b0, r});
    if (r) chk({tag, "_addr"}, imem.imem_addr, a);
    chk({tag, "_busy"}, {31'b0, fetch_busy}, {31'b0, b});
  endtask

  task automatic push(input logic [31:0] addr);
    sb_t e;
    e.instr = addr ^ key;
    e.pc    = addr + 32'd4;
    sbq.push_back(e);
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{0, 1'b0, 1'b1, 32'h04, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{0, 1'b0, 1'b1, 32'h08, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{2, 1'b0, 1'b1, 32'h0C, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{2, 1'b0, 1'b1, 32'h0C, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{2, 1'b0, 1'b1, 32'h0C, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; stall_fetch = 1'b0; stall_decode = 1'b0; flush_decode = 1'b0;
    pcsrc_decode = 1'b0; jump_decode = 1'b0; pc_branch = '0; pc_jump = '0;
    nxt(); nxt();
    #1;
    chk("rst_req", {31'b0, imem.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, valid_decode}, 32'd0);
    chk("rst_instr", instr_decode, 32'd0);
    chk("rst_pc", pc_decode, 32'd0);
    rst = 1'b0;

    // Zero-wait streaming, then a two-wait-state access.
    for (int i = 0; i < 7; i++) begin
      waitst = vecs[i].waitst;
      stall_decode = vecs[i].sd;
      bus($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].busy);
      chk($sformatf("vec%0d_valid", i), {31'b0, valid_decode}, {31'b0, vecs[i].valid});
      if (vecs[i].ack && !vecs[i].sd) push(vecs[i].addr);
      nxt();
    end

    // stall_decode on ack: word buffered in HOLD, delivered on release.
    key = 32'h0000_1220; stall_decode = 1'b1;
    bus("hold_ack", 1'b1, 32'h14, 1'b0);
    nxt();
    bus("hold_wait", 1'b0, 32'h14, 1'b0);
    chk("hold_keep_instr", instr_decode, 32'h10);
    chk("hold_keep_valid", {31'b0, valid_decode}, 32'd1);
    nxt();
    stall_decode = 1'b0;
    bus("hold_rel", 1'b0, 32'h14, 1'b0);
    sbq.push_back('{32'h0000_1234, 32'h18});
    nxt();
    bus("after_hold", 1'b1, 32'h18, 1'b0);
    push(32'h18);
    nxt();

    // Branch + flush with ack in the same cycle.
    pcsrc_decode = 1'b1; pc_branch = 32'h40; flush_decode = 1'b1;
    bus("br_ack", 1'b1, 32'h1C, 1'b0);
    nxt();
    pcsrc_decode = 1'b0; flush_decode = 1'b0;
    bus("br_target", 1'b1, 32'h40, 1'b0);
    chk("br_flush_valid", {31'b0, valid_decode}, 32'd0);
    push(32'h40);
    nxt();

    // Jump while a request is outstanding: drain then refetch at target.
    waitst = 2; jump_decode = 1'b1; pc_jump = 32'h80; flush_decode = 1'b1;
    bus("jmp_issue", 1'b1, 32'h44, 1'b1);
    nxt();
    jump_decode = 1'b0; flush_decode = 1'b0;
    bus("drain1", 1'b1, 32'h44, 1'b1);
    chk("drain1_valid", {31'b0, valid_decode}, 32'd0);
    nxt();
    bus("drain_ack", 1'b1, 32'h44, 1'b1);
    nxt();
    bus("jmp_target", 1'b1, 32'h80, 1'b1);
    chk("jmp_discard_valid", {31'b0, valid_decode}, 32'd0);

    // Two redirects in DRAIN: last wins, pcsrc beats jump.
    jump_decode = 1'b1; pc_jump = 32'hC0;
    nxt();
    pcsrc_decode = 1'b1; pc_branch = 32'hD0; pc_jump = 32'hE0;
    bus("drain2_redir", 1'b1, 32'h80, 1'b1);
    nxt();
    pcsrc_decode = 1'b0; jump_decode = 1'b0;
    bus("drain2_ack", 1'b1, 32'h80, 1'b1);
    nxt();
    bus("last_target", 1'b1, 32'hD0, 1'b1);
    nxt();

    // Reset with a request outstanding.
    rst = 1'b1;
    #1;
    chk("rst_mid_req", {31'b0, imem.imem_req}, 32'd0);
    nxt();
    #1;
    chk("rst_mid_req2", {31'b0, imem.imem_req}, 32'd0);
    chk("rst_mid_valid", {31'b0, valid_decode}, 32'd0);
    chk("rst_mid_pc", pc_decode, 32'd0);
    rst = 1'b0; waitst = 0;
    bus("rst_refetch", 1'b1, 32'h0, 1'b0);
    push(32'h0);
    nxt();

    // stall_fetch suppresses new requests but not an outstanding one.
    stall_fetch = 1'b1;
    bus("sf_idle", 1'b0, 32'h4, 1'b0);
    nxt();
    stall_fetch = 1'b0; waitst = 2;
    bus("sf_issue", 1'b1, 32'h4, 1'b1);
    nxt();
    stall_fetch = 1'b1;
    bus("sf_keep", 1'b1, 32'h4, 1'b1);
    nxt();
    bus("sf_ack", 1'b1, 32'h4, 1'b0);
    push(32'h4);
    nxt();

    // PC wrap at the top of the address space.
    stall_fetch = 1'b0; waitst = 0; jump_decode = 1'b1; pc_jump = 32'hFFFF_FFFC;
    bus("wrap_jmp", 1'b1, 32'h8, 1'b0);
    nxt();
    jump_decode = 1'b0;
    bus("wrap_top", 1'b1, 32'hFFFF_FFFC, 1'b0);
    push(32'hFFFF_FFFC);
    nxt();
    bus("wrap_zero", 1'b1, 32'h0, 1'b0);
    push(32'h0);
    nxt();
    stall_fetch = 1'b1;
    nxt(); nxt();
    chk("sb_empty", sbq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
